srcnn_frame_controller: RTL and testbench

- Frame-level sequencer wrapped around the SRCNN convolution pipeline, between the DMA pixel stream and the core.
- Admits exactly a programmed number of Height×Width frames into the core and counts the core's output pixels.
- Generates start-of-frame and end-of-frame sideband and a completion pulse.
- On abort, pads the partially admitted frame with zeros and discards the in-flight outputs, so the core's line buffers stay frame-aligned.

---
 rtl/srcnn_frame_controller.sv | 134 +++++++++++++
 tb/tb_srcnn_frame_controller.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/srcnn_frame_controller.sv
// srcnn_frame_controller: admits a programmed number of frames into the SRCNN core, counts its outputs and pads on abort
// Ports: clock_i/reset_ni clock and async active-low reset; start_i/frames_i/abort_i job control;
//   busy_o/done_o/aborted_o/error_o/frames_done_o status; s_* DMA pixel stream in; core_* core input
//   and output streams; m_* result stream with start-of-frame and end-of-frame sideband.
module srcnn_frame_controller #(
  parameter int Height          = 600,
  parameter int Width           = 800,
  parameter int ActivationWidth = 10,
  parameter int FrameCountWidth = 16
) (
  input  logic                         clock_i,
  input  logic                         reset_ni,
  input  logic                         start_i,
  input  logic [FrameCountWidth-1:0]   frames_i,
  input  logic                         abort_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         aborted_o,
  output logic                         error_o,
  output logic [FrameCountWidth-1:0]   frames_done_o,
  input  logic                         s_valid_i,
  output logic                         s_ready_o,
  input  logic [3*ActivationWidth-1:0] s_data_i,
  input  logic                         s_last_i,
  output logic                         core_valid_o,
  input  logic                         core_ready_i,
  output logic [3*ActivationWidth-1:0] core_data_o,
  input  logic                         core_valid_i,
  output logic                         core_ready_o,
  input  logic [3*ActivationWidth-1:0] core_data_i,
  output logic                         m_valid_o,
  input  logic                         m_ready_i,
  output logic [3*ActivationWidth-1:0] m_data_o,
  output logic                         m_sof_o,
  output logic                         m_last_o
);
  localparam int XW = (Width > 1) ? $clog2(Width) : 1;
  localparam int YW = (Height > 1) ? $clog2(Height) : 1;
  localparam int FW = FrameCountWidth;
  localparam logic [XW-1:0] XMAX = XW'(Width - 1);
  localparam logic [YW-1:0] YMAX = YW'(Height - 1);
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, FLUSH, DONE} state_t;
  state_t state, state_n;
  logic [XW-1:0] in_x, in_x_n, out_x, out_x_n;
  logic [YW-1:0] in_y, in_y_n, out_y, out_y_n;
  logic [FW-1:0] in_frames, in_frames_n, out_frames, out_frames_n, target, frames_done;
  logic start_ok, in_gate, out_pass, flush, pad, abort_ok;
  logic s_hs, in_hs, out_hs, in_eol, in_eof, out_eol, out_eof;
  assign start_ok = state == IDLE && start_i && frames_i != '0;
  assign in_gate  = state == RUN && in_frames < target;
  assign out_pass = state == RUN || state == DRAIN;
  assign flush    = state == FLUSH;
  // zero padding completes the partially admitted frame so the core's line buffers stay aligned
  assign pad      = flush && (in_x != '0 || in_y != '0);
  assign s_ready_o    = in_gate & core_ready_i;
  assign core_valid_o = in_gate ? s_valid_i : pad;
  assign core_data_o  = in_gate ? s_data_i : '0;
  // while flushing, in-flight core results are accepted and dropped
  assign core_ready_o = out_pass ? m_ready_i : flush;
  assign m_valid_o    = out_pass & core_valid_i;
  assign m_data_o     = out_pass ? core_data_i : '0;
  assign m_sof_o      = m_valid_o && out_x == '0 && out_y == '0;
  assign m_last_o     = m_valid_o && out_eof;
  assign s_hs   = s_valid_i & s_ready_o;
  assign in_hs  = core_valid_o & core_ready_i;
  assign out_hs = core_valid_i & core_ready_o;
  assign in_eol  = in_x == XMAX;
  assign in_eof  = in_eol && in_y == YMAX;
  assign out_eol = out_x == XMAX;
  assign out_eof = out_eol && out_y == YMAX;
  assign in_x_n       = in_hs ? (in_eol ? '0 : in_x + 1'b1) : in_x;
  assign in_y_n       = (in_hs && in_eol) ? (in_y == YMAX ? '0 : in_y + 1'b1) : in_y;
  assign in_frames_n  = in_frames + FW'(in_hs && in_eof);
  assign out_x_n      = out_hs ? (out_eol ? '0 : out_x + 1'b1) : out_x;
  assign out_y_n      = (out_hs && out_eol) ? (out_y == YMAX ? '0 : out_y + 1'b1) : out_y;
  assign out_frames_n = out_frames + FW'(out_hs && out_eof);
  // completion outranks a same-cycle abort
  assign abort_ok = abort_i && out_pass && out_frames != target;
  assign frames_done_o = frames_done;
  always_ff @(posedge clock_i or negedge reset_ni)
    if (!reset_ni) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    busy_o  = state != IDLE;
    done_o  = state == DONE;
    case (state)
      IDLE:       state_n = start_ok ? RUN : IDLE;
      RUN, DRAIN: state_n = out_frames == target ? DONE :
                            abort_ok ? FLUSH :
                            (state == RUN && in_frames == target) ? DRAIN : state;
      FLUSH:      state_n = (!pad && out_frames == target) ? DONE : FLUSH;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock_i or negedge reset_ni)
    if (!reset_ni) begin
      in_x        <= '0;
      in_y        <= '0;
      in_frames   <= '0;
      out_x       <= '0;
      out_y       <= '0;
      out_frames  <= '0;
      target      <= '0;
      frames_done <= '0;
      aborted_o   <= 1'b0;
      error_o     <= 1'b0;
    end else if (start_ok) begin
      in_x        <= '0;
      in_y        <= '0;
      in_frames   <= '0;
      out_x       <= '0;
      out_y       <= '0;
      out_frames  <= '0;
      target      <= frames_i;
      frames_done <= '0;
      aborted_o   <= 1'b0;
      error_o     <= 1'b0;
    end else begin
      in_x       <= in_x_n;
      in_y       <= in_y_n;
      in_frames  <= in_frames_n;
      out_x      <= out_x_n;
      out_y      <= out_y_n;
      out_frames <= out_frames_n;
      // the abort-cycle handshake is already folded into the *_n counters
      if (abort_ok) begin
        target    <= in_frames_n + FW'(in_x_n != '0 || in_y_n != '0);
        aborted_o <= 1'b1;
      end
      if (s_hs && s_last_i != in_eof) error_o <= 1'b1;
      if (out_pass && out_hs && out_eof) frames_done <= frames_done + 1'b1;
    end
endmodule

// File: tb/tb_srcnn_frame_controller.sv
// tb_srcnn_frame_controller: scoreboard bench for srcnn_frame_controller with a 5-cycle delay core model
module tb_srcnn_frame_controller;
  localparam int H = 3, W = 4, AW = 10, FW = 16, PW = 3 * AW, PX = H * W;
  logic clock_i = 0, reset_ni = 0, start_i = 0, abort_i = 0;
  logic [FW-1:0] frames_i = '0;
  logic s_valid_i = 0, s_last_i = 0, core_ready_i = 1, core_valid_i = 0, m_ready_i = 0;
  logic [PW-1:0] s_data_i = '0, core_data_i = '0;
  logic busy_o, done_o, aborted_o, error_o, s_ready_o, core_valid_o, core_ready_o;
  logic m_valid_o, m_sof_o, m_last_o;
  logic [FW-1:0] frames_done_o;
  logic [PW-1:0] core_data_o, m_data_o;
  srcnn_frame_controller #(.Height(H), .Width(W), .ActivationWidth(AW), .FrameCountWidth(FW)) dut (
    .clock_i(clock_i), .reset_ni(reset_ni), .start_i(start_i), .frames_i(frames_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o), .error_o(error_o),
    .frames_done_o(frames_done_o), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .s_last_i(s_last_i), .core_valid_o(core_valid_o), .core_ready_i(core_ready_i),
    .core_data_o(core_data_o), .core_valid_i(core_valid_i), .core_ready_o(core_ready_o),
    .core_data_i(core_data_i), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .m_sof_o(m_sof_o), .m_last_o(m_last_o));
  always #5 clock_i = ~clock_i;
  typedef struct {logic [PW-1:0] d; int t;} ent_t;
  ent_t cq[$];
  int cyc;
  always @(posedge clock_i or negedge reset_ni)
    if (!reset_ni) begin
      cq.delete();
      cyc = 0;
      core_valid_i <= 1'b0;
      core_data_i <= '0;
    end else begin
      if (core_valid_i && core_ready_o) void'(cq.pop_front());
      if (core_valid_o && core_ready_i) cq.push_back('{core_data_o, cyc});
      cyc++;
      core_valid_i <= cq.size() > 0 && cyc - cq[0].t >= 5;
      core_data_i <= cq.size() > 0 ? cq[0].d : '0;
    end
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] expv, od, cd;
  bit ia, oa, cin, dn, osof, olast;
  int total = 0, bad = 0;
  task automatic step(input bit sv, input bit sl, input bit mr, input bit ab);
    @(negedge clock_i);
    s_valid_i = sv;
    s_last_i = sl;
    m_ready_i = mr;
    abort_i = ab;
    s_data_i = PW'($urandom);
    #1;
    ia = s_valid_i && s_ready_o;
    oa = m_valid_o && m_ready_i;
    cin = core_valid_o && core_ready_i;
    cd = core_data_o;
    od = m_data_o;
    osof = m_sof_o;
    olast = m_last_o;
    dn = done_o;
    if (ia) exp_q.push_back(s_data_i);
  endtask
  task automatic issue_start(input int n);
    @(negedge clock_i);
    s_valid_i = 0;
    abort_i = 0;
    start_i = 1;
    frames_i = FW'(n);
    exp_q.delete();
    @(posedge clock_i);
    #1 start_i = 0;
  endtask
  task automatic test_reset();
    s_valid_i = 1;
    m_ready_i = 1;
    repeat (2) @(negedge clock_i);
    total++;
    if ({busy_o, done_o, aborted_o, error_o} !== 4'b0) begin
      bad++;
      $display("FAIL reset_status: got %b want 0000", {busy_o, done_o, aborted_o, error_o});
    end
    total++;
    if (frames_done_o !== '0) begin bad++; $display("FAIL reset_frames_done: got %0d want 0", frames_done_o); end
    total++;
    if ({s_ready_o, core_valid_o, core_ready_o, m_valid_o} !== 4'b0) begin
      bad++;
      $display("FAIL reset_gates: got %b want 0000", {s_ready_o, core_valid_o, core_ready_o, m_valid_o});
    end
    reset_ni = 1;
  endtask
  task automatic test_two_frames();
    int in_n = 0, out_n = 0, dones = 0, dn_at = -1;
    issue_start(2);
    for (int c = 0; c < 300; c++) begin
      step(1, in_n % PX == PX - 1, 1, 0);
      if (ia) in_n++;
      if (oa) begin
        expv = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
        total++;
        if (od !== expv || osof !== (out_n % PX == 0) || olast !== (out_n % PX == PX - 1)) begin
          bad++;
          $display("FAIL two_frames_px%0d: got data=%h sof=%b last=%b want data=%h sof=%b last=%b",
                   out_n, od, osof, olast, expv, out_n % PX == 0, out_n % PX == PX - 1);
        end
        out_n++;
      end
      if (dn) begin dones++; dn_at = out_n; end
      if (dones > 0 && !busy_o) break;
    end
    total++;
    if (in_n != 2 * PX || out_n != 2 * PX) begin bad++; $display("FAIL two_frames_count: got in=%0d out=%0d want 24/24", in_n, out_n); end
    total++;
    if (dones != 1 || dn_at != 2 * PX) begin bad++; $display("FAIL two_frames_done: got pulses=%0d at_out=%0d want 1 at 24", dones, dn_at); end
    total++;
    if (frames_done_o !== 16'd2 || error_o !== 1'b0) begin
      bad++;
      $display("FAIL two_frames_status: got frames_done=%0d error=%b want 2 0", frames_done_o, error_o);
    end
  endtask
  task automatic test_stall();
    int in_n = 0, out_n = 0, dones = 0, dn_at = -1;
    bit sv, blocked = 0;
    issue_start(1);
    for (int c = 0; c < 600; c++) begin
      sv = 1'($urandom_range(0, 1));
      step(sv, in_n % PX == PX - 1, 1'($urandom_range(0, 1)), 0);
      if (sv && in_n == PX && !blocked) begin
        blocked = 1;
        total++;
        if (s_ready_o !== 1'b0) begin bad++; $display("FAIL stall_13th_ready: got %b want 0", s_ready_o); end
      end
      if (ia) in_n++;
      if (oa) begin
        expv = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
        total++;
        if (od !== expv || osof !== (out_n % PX == 0) || olast !== (out_n % PX == PX - 1)) begin
          bad++;
          $display("FAIL stall_px%0d: got data=%h sof=%b last=%b want data=%h", out_n, od, osof, olast, expv);
        end
        out_n++;
      end
      if (dn) begin dones++; dn_at = out_n; end
      if (dones > 0 && !busy_o) break;
    end
    total++;
    if (in_n != PX || out_n != PX) begin bad++; $display("FAIL stall_count: got in=%0d out=%0d want 12/12", in_n, out_n); end
    total++;
    if (dones != 1 || dn_at != PX) begin bad++; $display("FAIL stall_done: got pulses=%0d at_out=%0d want 1 at 12", dones, dn_at); end
  endtask
  task automatic test_last_error();
    int in_n = 0, out_n = 0, dones = 0, dn_at = -1;
    bit chk_next = 0;
    issue_start(2);
    for (int c = 0; c < 300; c++) begin
      step(1, in_n % PX == PX - 1 || in_n == 10, 1, 0);
      if (chk_next) begin
        chk_next = 0;
        total++;
        if (error_o !== 1'b1) begin bad++; $display("FAIL last_err_set: got %b want 1", error_o); end
      end
      if (ia && in_n == 10) begin
        chk_next = 1;
        total++;
        if (error_o !== 1'b0) begin bad++; $display("FAIL last_err_early: got %b want 0", error_o); end
      end
      if (ia) in_n++;
      if (oa) begin
        expv = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
        total++;
        if (od !== expv || osof !== (out_n % PX == 0) || olast !== (out_n % PX == PX - 1)) begin
          bad++;
          $display("FAIL last_err_px%0d: got data=%h sof=%b last=%b want data=%h", out_n, od, osof, olast, expv);
        end
        out_n++;
      end
      if (dn) begin dones++; dn_at = out_n; end
      if (dones > 0 && !busy_o) break;
    end
    total++;
    if (dones != 1 || dn_at != 2 * PX || in_n != 2 * PX) begin
      bad++;
      $display("FAIL last_err_done: got pulses=%0d at_out=%0d in=%0d want 1 24 24", dones, dn_at, in_n);
    end
    total++;
    if (error_o !== 1'b1 || frames_done_o !== 16'd2) begin
      bad++;
      $display("FAIL last_err_status: got error=%b frames_done=%0d want 1 2", error_o, frames_done_o);
    end
  endtask
  task automatic test_abort();
    int in_n = 0, out_n = 0, dones = 0, pads = 0;
    bit ab, aborted = 0;
    issue_start(3);
    total++;
    if (error_o !== 1'b0) begin bad++; $display("FAIL abort_err_clear: got %b want 0", error_o); end
    for (int c = 0; c < 400; c++) begin
      ab = in_n == 17 && !aborted;
      step(aborted || in_n < 17, in_n % PX == PX - 1, 1, ab);
      if (ia) in_n++;
      if (oa) begin
        expv = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
        total++;
        if (od !== expv || osof !== (out_n % PX == 0) || olast !== (out_n % PX == PX - 1)) begin
          bad++;
          $display("FAIL abort_px%0d: got data=%h sof=%b last=%b want data=%h", out_n, od, osof, olast, expv);
        end
        out_n++;
      end
      if (aborted && busy_o && !dn) begin
        total++;
        if (core_ready_o !== 1'b1 || m_valid_o !== 1'b0 || s_ready_o !== 1'b0) begin
          bad++;
          $display("FAIL abort_flush_gates: got core_ready=%b m_valid=%b s_ready=%b want 1 0 0", core_ready_o, m_valid_o, s_ready_o);
        end
        if (cin) begin
          pads++;
          total++;
          if (cd !== '0) begin bad++; $display("FAIL abort_pad_data: got %h want 0", cd); end
        end
      end
      if (dn) begin
        dones++;
        total++;
        if (cq.size() != 0) begin bad++; $display("FAIL abort_early_done: got %0d core items left want 0", cq.size()); end
      end
      if (ab) aborted = 1;
      if (dones > 0 && !busy_o) break;
    end
    total++;
    if (in_n != 17 || pads != 7 || dones != 1) begin
      bad++;
      $display("FAIL abort_count: got in=%0d pads=%0d pulses=%0d want 17 7 1", in_n, pads, dones);
    end
    total++;
    if (aborted_o !== 1'b1 || frames_done_o !== FW'(out_n / PX)) begin
      bad++;
      $display("FAIL abort_status: got aborted=%b frames_done=%0d want 1 %0d", aborted_o, frames_done_o, out_n / PX);
    end
  endtask
  task automatic test_reset_mid();
    int in_n = 0, out_n = 0, dones = 0;
    issue_start(1);
    for (int c = 0; c < 20 && in_n < 5; c++) begin
      step(1, 0, 1, 0);
      if (ia) in_n++;
    end
    #2 reset_ni = 0;
    #1;
    total++;
    if ({busy_o, s_ready_o, core_valid_o, core_ready_o, m_valid_o, aborted_o, error_o} !== 7'b0 || frames_done_o !== '0) begin
      bad++;
      $display("FAIL reset_mid_async: got busy=%b s_ready=%b core_valid=%b core_ready=%b m_valid=%b want all 0",
               busy_o, s_ready_o, core_valid_o, core_ready_o, m_valid_o);
    end
    @(negedge clock_i);
    reset_ni = 1;
    #1;
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_mid_busy: got %b want 0", busy_o); end
    in_n = 0;
    issue_start(1);
    for (int c = 0; c < 300; c++) begin
      step(1, in_n % PX == PX - 1, 1, 0);
      if (ia) in_n++;
      if (oa) begin
        expv = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
        total++;
        if (od !== expv || osof !== (out_n % PX == 0) || olast !== (out_n % PX == PX - 1)) begin
          bad++;
          $display("FAIL reset_mid_px%0d: got data=%h sof=%b last=%b want data=%h", out_n, od, osof, olast, expv);
        end
        out_n++;
      end
      if (dn) dones++;
      if (dones > 0 && !busy_o) break;
    end
    total++;
    if (in_n != PX || out_n != PX || dones != 1 || frames_done_o !== 16'd1) begin
      bad++;
      $display("FAIL reset_mid_job: got in=%0d out=%0d pulses=%0d frames_done=%0d want 12 12 1 1", in_n, out_n, dones, frames_done_o);
    end
  endtask
  task automatic test_start_ignore();
    int in_n = 0, out_n = 0, dones = 0;
    @(negedge clock_i);
    start_i = 1;
    frames_i = '0;
    @(negedge clock_i);
    start_i = 0;
    #1;
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL zero_start_busy: got %b want 0", busy_o); end
    issue_start(1);
    for (int c = 0; c < 300; c++) begin
      if (c == 3) begin start_i = 1; frames_i = 16'd5; end
      if (c == 4) start_i = 0;
      step(1, in_n % PX == PX - 1, 1, 0);
      if (ia) in_n++;
      if (oa) begin
        expv = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
        total++;
        if (od !== expv) begin bad++; $display("FAIL restart_px%0d: got %h want %h", out_n, od, expv); end
        out_n++;
      end
      if (dn) dones++;
      if (dones > 0 && !busy_o) break;
    end
    start_i = 0;
    total++;
    if (in_n != PX || out_n != PX || dones != 1 || frames_done_o !== 16'd1) begin
      bad++;
      $display("FAIL restart_ignored: got in=%0d out=%0d pulses=%0d frames_done=%0d want 12 12 1 1", in_n, out_n, dones, frames_done_o);
    end
  endtask
  initial begin
    test_reset();
    test_two_frames();
    test_stall();
    test_last_error();
    test_abort();
    test_reset_mid();
    test_start_ignore();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
